// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode/execute control FSM driving PC strobes and instruction reads
module fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [2:0]        state_o,
    output logic              halted,
    output logic              fault
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        SYNC   = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } state_t;
    state_t        state, nxt;
    logic [CW-1:0] wait_cnt;
    logic          halt_pend, br_pend;
    logic          active;
    assign active = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == SYNC);
    // next-state decode; the unused encoding falls back to IDLE
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = run ? FETCH : IDLE;
            FETCH:   nxt = mem_ack ? DECODE : (wait_cnt == CW'(TIMEOUT - 1)) ? FAULT : FETCH;
            DECODE:  nxt = EXEC;
            EXEC:    nxt = exec_done ? SYNC : EXEC;
            SYNC:    nxt = (halt_pend || halt_req) ? HALT : FETCH;
            HALT:    nxt = HALT;
            FAULT:   nxt = FAULT;
            default: nxt = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end
    // instruction latch, ack watchdog, sticky halt and pending branch bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir           <= '0;
            wait_cnt     <= '0;
            halt_pend    <= 1'b0;
            br_pend      <= 1'b0;
            pc_load_addr <= '0;
        end else begin
            if (state == FETCH) begin
                if (mem_ack) begin
                    ir       <= mem_rdata;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
            if (active && halt_req) halt_pend <= 1'b1;
            if (state == EXEC && exec_done) begin
                br_pend <= branch_taken;
                if (branch_taken) pc_load_addr <= branch_target;
            end
            if (state == SYNC) br_pend <= 1'b0;
        end
    end
    assign mem_req  = (state == FETCH);
    assign mem_addr = (state == FETCH) ? pc : '0;
    assign pc_inc   = (state == DECODE);
    assign ir_valid = (state == DECODE);
    assign pc_load  = (state == SYNC) && br_pend;
    assign halted   = (state == HALT);
    assign fault    = (state == FAULT);
    assign state_o  = state;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenario bench for fetch_sequencer with a simple PC block model
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0, halt_req = 1'b0;
    logic [7:0] pc;
    logic [7:0] pc_init = 8'h00;
    logic       pc_inc, pc_load, mem_req, mem_ack = 1'b0, ir_valid;
    logic       exec_done = 1'b0, branch_taken = 1'b0, halted, fault;
    logic [7:0] pc_load_addr, mem_addr, mem_rdata = 8'h00, ir, branch_target = 8'h00;
    logic [2:0] state_o;
    int         checks = 0;
    int         errors = 0;

    fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .halt_req(halt_req), .pc(pc),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done), .branch_taken(branch_taken),
        .branch_target(branch_target), .state_o(state_o), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // PC block: load beats increment, reset to the scenario's start address
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     pc <= pc_init;
        else if (pc_load) pc <= pc_load_addr;
        else if (pc_inc)  pc <= pc + 8'h01;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] start);
        pc_init = start;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #7;
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        checks++; if ({mem_req, pc_inc, pc_load, ir_valid, halted, fault} !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b want 000000", {mem_req, pc_inc, pc_load, ir_valid, halted, fault}); end
        checks++; if ({ir, pc_load_addr, mem_addr} !== 24'h0) begin errors++; $display("FAIL reset_regs got %h want 000000", {ir, pc_load_addr, mem_addr}); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", state_o); end
    endtask

    task automatic test_fetch();
        run = 1'b1;
        step();
        run = 1'b0;
        checks++; if (state_o !== 3'd1 || mem_req !== 1'b1) begin errors++; $display("FAIL fetch_enter state %0d req %b want 1 1", state_o, mem_req); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL fetch_addr got %h want 00", mem_addr); end
        step();
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL fetch_wait got %0d want 1", state_o); end
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        step();
        mem_ack = 1'b0;
        checks++; if (state_o !== 3'd2 || ir !== 8'hA5) begin errors++; $display("FAIL decode state %0d ir %h want 2 a5", state_o, ir); end
        checks++; if ({pc_inc, ir_valid, pc_load, mem_req} !== 4'b1100) begin errors++; $display("FAIL decode_strobes got %b want 1100", {pc_inc, ir_valid, pc_load, mem_req}); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL decode_addr got %h want 00", mem_addr); end
        step();
        checks++; if (state_o !== 3'd3 || pc_inc !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL exec state %0d inc %b val %b want 3 0 0", state_o, pc_inc, ir_valid); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL pc_after_inc got %h want 01", pc); end
    endtask

    task automatic test_branch();
        exec_done = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        step();
        exec_done = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        checks++; if (state_o !== 3'd4 || pc_load !== 1'b1 || pc_inc !== 1'b0) begin errors++; $display("FAIL sync_load state %0d load %b inc %b want 4 1 0", state_o, pc_load, pc_inc); end
        checks++; if (pc_load_addr !== 8'h40) begin errors++; $display("FAIL load_addr got %h want 40", pc_load_addr); end
        step();
        checks++; if (state_o !== 3'd1 || pc_load !== 1'b0) begin errors++; $display("FAIL refetch state %0d load %b want 1 0", state_o, pc_load); end
        checks++; if (mem_addr !== 8'h40) begin errors++; $display("FAIL branch_addr got %h want 40", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        step();
        mem_ack = 1'b0;
        checks++; if (state_o !== 3'd2 || ir !== 8'h3C) begin errors++; $display("FAIL first_cycle_ack state %0d ir %h want 2 3c", state_o, ir); end
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        checks++; if (state_o !== 3'd4 || pc_load !== 1'b0) begin errors++; $display("FAIL sync_noload state %0d load %b want 4 0", state_o, pc_load); end
        step();
        checks++; if (state_o !== 3'd1 || mem_addr !== 8'h41) begin errors++; $display("FAIL seq_addr state %0d addr %h want 1 41", state_o, mem_addr); end
    endtask

    task automatic test_timeout();
        repeat (14) step();
        checks++; if (state_o !== 3'd1 || fault !== 1'b0) begin errors++; $display("FAIL pre_timeout state %0d fault %b want 1 0", state_o, fault); end
        step();
        checks++; if (state_o !== 3'd6 || fault !== 1'b1 || mem_req !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL timeout state %0d fault %b req %b halt %b want 6 1 0 0", state_o, fault, mem_req, halted); end
        mem_ack = 1'b1; mem_rdata = 8'hFF; run = 1'b1;
        repeat (3) step();
        mem_ack = 1'b0; run = 1'b0;
        checks++; if (state_o !== 3'd6 || ir !== 8'h3C || mem_req !== 1'b0) begin errors++; $display("FAIL fault_sticky state %0d ir %h req %b want 6 3c 0", state_o, ir, mem_req); end
    endtask

    task automatic test_halt();
        do_reset(8'h20);
        run = 1'b1;
        step();
        run = 1'b0;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (state_o !== 3'd1 || mem_addr !== 8'h20) begin errors++; $display("FAIL halt_fetch state %0d addr %h want 1 20", state_o, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 8'h77;
        step();
        mem_ack = 1'b0;
        checks++; if (pc_inc !== 1'b1 || ir !== 8'h77) begin errors++; $display("FAIL halt_completes inc %b ir %h want 1 77", pc_inc, ir); end
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL halt_sync got %0d want 4", state_o); end
        step();
        checks++; if (state_o !== 3'd5 || halted !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL halted state %0d halt %b req %b want 5 1 0", state_o, halted, mem_req); end
        run = 1'b1;
        repeat (3) step();
        run = 1'b0;
        checks++; if (state_o !== 3'd5 || mem_req !== 1'b0 || pc !== 8'h21) begin errors++; $display("FAIL halt_sticky state %0d req %b pc %h want 5 0 21", state_o, mem_req, pc); end
    endtask

    task automatic test_async_reset();
        do_reset(8'h00);
        run = 1'b1;
        step();
        run = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        step();
        mem_ack = 1'b0;
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        step();
        checks++; if (state_o !== 3'd1 || ir !== 8'h5A || mem_addr !== 8'h01) begin errors++; $display("FAIL pre_reset state %0d ir %h addr %h want 1 5a 01", state_o, ir, mem_addr); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || state_o !== 3'd0 || ir !== 8'h00) begin errors++; $display("FAIL async_reset req %b state %0d ir %h want 0 0 00", mem_req, state_o, ir); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        run = 1'b1;
        step();
        run = 1'b0;
        checks++; if (state_o !== 3'd1 || mem_req !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL restart state %0d req %b addr %h want 1 1 00", state_o, mem_req, mem_addr); end
    endtask

    task automatic test_halt_branch();
        mem_ack = 1'b1; mem_rdata = 8'h11;
        step();
        mem_ack = 1'b0;
        step();
        exec_done = 1'b1; halt_req = 1'b1; branch_taken = 1'b1; branch_target = 8'h10;
        step();
        exec_done = 1'b0; halt_req = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        checks++; if (state_o !== 3'd4 || pc_load !== 1'b1 || pc_load_addr !== 8'h10) begin errors++; $display("FAIL hb_sync state %0d load %b addr %h want 4 1 10", state_o, pc_load, pc_load_addr); end
        step();
        checks++; if (state_o !== 3'd5 || halted !== 1'b1 || pc_load !== 1'b0 || pc !== 8'h10) begin errors++; $display("FAIL hb_halt state %0d halt %b load %b pc %h want 5 1 0 10", state_o, halted, pc_load, pc); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_timeout();
        test_halt();
        test_async_reset();
        test_halt_branch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
